argon_fetch_unit: RTL and testbench
===================================

// Module: argon_fetch_unit
// PURPOSE
//   Instruction fetch stage directly upstream of the Argon instruction register/decode.
//   Owns the fetch PC, issues single-outstanding word reads to instruction memory over a
//   valid/ready request + valid response interface, and holds each fetched word with its PC
//   for decode via a valid/ready handshake. Accepts jump/branch redirects from execute.
// PARAMETERS
//   RESET_PC    32'h0000_0000  fetch address after reset
//   CNT_W       32             width of o_fetch_count
// PORTS
//   i_clk              in   1      clock
//   i_reset            in   1      asynchronous, active-high reset
//   i_halt             in   1      1 = issue no new memory requests
//   o_mem_req_valid    out  1      read request valid
//   i_mem_req_ready    in   1      memory accepts request (sampled with valid)
//   o_mem_addr         out  32     word address of request (bits [1:0] = 00)
//   i_mem_rsp_valid    in   1      read data valid, one pulse per accepted request
//   i_mem_rsp_data     in   32     instruction word
//   o_instr_valid      out  1      o_instruction/o_instr_pc valid for decode
//   i_instr_ready      in   1      decode consumes instruction
//   o_instruction      out  32     fetched word (opcode in [5:0])
//   o_instr_pc         out  32     PC of o_instruction
//   o_pc_plus4         out  32     o_instr_pc + 4 (link value / sequential target)
//   i_redirect_valid   in   1      take new fetch target
//   i_redirect_target  in   32     new fetch PC
//   o_fetch_count      out  CNT_W  instructions delivered to decode (valid&ready count)
//   o_fault            out  1      misaligned redirect fault (ARGON_FETCH_ALIGN_CHECK_EN only)
// BEHAVIOUR
//   - Reset (async): r_pc=RESET_PC, state=REQ, all outputs 0, o_fetch_count=0, squash=0.
//   - States: REQ, WAIT, HOLD (+ FAULT with macro).
//   - REQ: o_mem_req_valid = ~i_halt; o_mem_addr = r_pc. valid&ready -> WAIT, r_req_pc<=r_pc.
//     Memory samples o_mem_addr only on valid&ready; addr may change while not accepted.
//   - WAIT: on i_mem_rsp_valid: o_instruction<=data, o_instr_pc<=r_req_pc,
//     o_pc_plus4<=r_req_pc+4, r_pc<=r_req_pc+4, -> HOLD. Response may arrive >=1 cycle after accept.
//   - HOLD: o_instr_valid=1, data stable until taken. valid&ready -> REQ, count+=1 (wraps 2^CNT_W).
//   - Latency: request accepted cycle N, response cycle N+k -> o_instr_valid at N+k+1.
//     Min 3 cycles/instruction (REQ, WAIT, HOLD) with k=1 and immediate ready.
//   - Redirect (r_pc<=target; target bits [1:0] handled per CONFIGURATION):
//     REQ, not accepted: stay REQ, next request uses target.
//     REQ, accepted same cycle: go WAIT with squash=1.
//     WAIT: squash=1; response (same cycle or later) discarded, then -> REQ. Redirect and
//       response in the same cycle: response discarded, -> REQ.
//     WAIT with squash=1 and another redirect: r_pc updated, still one response discarded.
//     HOLD: o_instr_valid drops next cycle, -> REQ. If i_instr_ready same cycle, handshake
//       completes (count+=1) and redirect still applied.
//   - i_halt affects only REQ; an outstanding request completes and HOLD delivers normally.
//   - PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
//   - Unused i_mem_rsp_valid in REQ/HOLD is ignored (protocol error, not flagged).
// CONFIGURATION
//   ARGON_FETCH_ALIGN_CHECK_EN defined: redirect with target[1:0]!=00 -> FAULT: o_fault=1,
//     no requests, o_instr_valid=0, outstanding response discarded; exit only by i_reset.
//   Not defined: target[1:0] forced to 00, no FAULT state, o_fault tied 0.
// TESTING
//   1 Reset, mem k=1, ready=1 -> addrs 0x0,0x4,0x8; o_instr_valid every 3rd cycle, count=3.
//   2 Response delayed k=4, decode ready low 5 cycles -> o_instruction/o_instr_pc held stable;
//     no second request issued until handshake.
//   3 Redirect 0x100 in WAIT, response 0xDEAD_BEEF next cycle -> word dropped,
//     next request addr 0x100, first delivered o_instr_pc=0x100, o_pc_plus4=0x104.
//   4 Redirect 0x40 in HOLD with i_instr_ready=1 -> count+1, next addr 0x40.
//   5 i_halt=1 during WAIT -> current word delivered, then o_mem_req_valid=0 until halt drops.
//   6 Redirect 0x102: macro on -> o_fault=1, no requests; macro off -> next addr 0x100.

Source files
------------

// File: rtl/argon_fetch_unit.sv
// -----------------------------------------------------------------------------
// argon_fetch_unit
//
// Instruction fetch stage feeding the Argon instruction register / decode.
// Owns the fetch PC and keeps at most one word read outstanding on the
// instruction memory port (valid/ready request, single-pulse valid response).
// Each fetched word is held together with its PC until decode takes it over a
// valid/ready handshake. Execute can redirect the fetch stream at any time.
//
// Optional feature macro: ARGON_FETCH_ALIGN_CHECK_EN
//   defined   : a redirect whose target has bits [1:0] != 00 parks the unit in
//               a terminal FAULT state (o_fault=1, no further requests or
//               deliveries) until i_reset.
//   undefined : redirect targets are silently word-aligned and o_fault is 0.
// -----------------------------------------------------------------------------
module argon_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_halt,
    output logic             o_mem_req_valid,
    input  logic             i_mem_req_ready,
    output logic [31:0]      o_mem_addr,
    input  logic             i_mem_rsp_valid,
    input  logic [31:0]      i_mem_rsp_data,
    output logic             o_instr_valid,
    input  logic             i_instr_ready,
    output logic [31:0]      o_instruction,
    output logic [31:0]      o_instr_pc,
    output logic [31:0]      o_pc_plus4,
    input  logic             i_redirect_valid,
    input  logic [31:0]      i_redirect_target,
    output logic [CNT_W-1:0] o_fetch_count,
    output logic             o_fault
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
`ifdef ARGON_FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;
`endif

    // Sequential successor of a fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    state_t      state_r;
    logic [31:0] pc_r;        // address of the next request to issue
    logic [31:0] req_pc_r;    // address of the request currently outstanding
    logic        squash_r;    // outstanding response must be thrown away

    logic [31:0] target_s;    // redirect target as it will be loaded into pc_r
    logic        req_fire_s;  // request handshake completes this cycle
    logic        take_s;      // decode handshake completes this cycle

    // -------------------------------------------------------------------------
    // Redirect target conditioning
    // -------------------------------------------------------------------------
`ifdef ARGON_FETCH_ALIGN_CHECK_EN
    logic misalign_s;         // redirect that must trap the unit
    logic fault_r;

    assign target_s   = i_redirect_target;
    assign misalign_s = i_redirect_valid & (i_redirect_target[1:0] != 2'b00);
    assign o_fault    = fault_r;
`else
    logic tgt_low_unused_s;

    // Low target bits are dropped: every fetch is word aligned.
    assign target_s         = {i_redirect_target[31:2], 2'b00};
    assign tgt_low_unused_s = ^i_redirect_target[1:0];
    assign o_fault          = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Memory request port
    // -------------------------------------------------------------------------
    // Request is offered straight from the REQ state so that halt takes effect
    // in the same cycle; nothing is offered while reset is asserted.
    assign o_mem_req_valid = (state_r == ST_REQ) & ~i_halt & ~i_reset;
    assign o_mem_addr      = pc_r;
    assign req_fire_s      = o_mem_req_valid & i_mem_req_ready;
    assign take_s          = o_instr_valid & i_instr_ready;

    // Fetch FSM: PC ownership, outstanding-request tracking, instruction hold
    // register and delivery counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r       <= ST_REQ;
            pc_r          <= RESET_PC;
            req_pc_r      <= 32'h0000_0000;
            squash_r      <= 1'b0;
            o_instr_valid <= 1'b0;
            o_instruction <= 32'h0000_0000;
            o_instr_pc    <= 32'h0000_0000;
            o_pc_plus4    <= 32'h0000_0000;
            o_fetch_count <= '0;
`ifdef ARGON_FETCH_ALIGN_CHECK_EN
            fault_r       <= 1'b0;
`endif
        end else begin
            // A completed decode handshake always counts, even when a redirect
            // arrives in the same cycle.
            if (take_s) begin
                o_fetch_count <= o_fetch_count + CNT_W'(1);
            end

            case (state_r)
                ST_REQ: begin
                    if (req_fire_s) begin
                        // The request already left with the old PC; a redirect
                        // in this same cycle makes its response stale.
                        state_r  <= ST_WAIT;
                        req_pc_r <= pc_r;
                        squash_r <= i_redirect_valid;
                    end
                    if (i_redirect_valid) begin
                        pc_r <= target_s;
                    end
                end

                ST_WAIT: begin
                    if (i_mem_rsp_valid) begin
                        squash_r <= 1'b0;
                        if (squash_r || i_redirect_valid) begin
                            // Stale word: drop it and refetch from pc_r.
                            state_r <= ST_REQ;
                        end else begin
                            state_r       <= ST_HOLD;
                            o_instr_valid <= 1'b1;
                            o_instruction <= i_mem_rsp_data;
                            o_instr_pc    <= req_pc_r;
                            o_pc_plus4    <= next_seq_pc(req_pc_r);
                            pc_r          <= next_seq_pc(req_pc_r);
                        end
                    end else if (i_redirect_valid) begin
                        // Only one response is ever outstanding, so a single
                        // squash flag covers any number of redirects here.
                        squash_r <= 1'b1;
                    end
                    if (i_redirect_valid) begin
                        pc_r <= target_s;
                    end
                end

                ST_HOLD: begin
                    if (i_instr_ready || i_redirect_valid) begin
                        state_r       <= ST_REQ;
                        o_instr_valid <= 1'b0;
                    end
                    if (i_redirect_valid) begin
                        pc_r <= target_s;
                    end
                end

`ifdef ARGON_FETCH_ALIGN_CHECK_EN
                ST_FAULT: begin
                    // Terminal: only reset leaves this state.
                    o_instr_valid <= 1'b0;
                    squash_r      <= 1'b0;
                    fault_r       <= 1'b1;
                end
`endif

                default: begin
                    // Unreachable encoding: restart fetch cleanly.
                    state_r       <= ST_REQ;
                    o_instr_valid <= 1'b0;
                    squash_r      <= 1'b0;
                end
            endcase

`ifdef ARGON_FETCH_ALIGN_CHECK_EN
            // Misaligned redirect overrides whatever the state decided; any
            // outstanding response is simply never looked at again.
            if (misalign_s) begin
                state_r       <= ST_FAULT;
                fault_r       <= 1'b1;
                o_instr_valid <= 1'b0;
                squash_r      <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_argon_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_argon_fetch_unit
//
// Directed bench for argon_fetch_unit. A transaction-level model (expected
// fetch address, outstanding request, held word, delivery count) is checked
// against the DUT on every cycle; the directed scenarios additionally pin
// hand-computed addresses, PCs and counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_argon_fetch_unit;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_halt;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_data;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instruction;
    logic [31:0] o_instr_pc;
    logic [31:0] o_pc_plus4;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_target;
    logic [31:0] o_fetch_count;
    logic        o_fault;

    always #5 clk = ~clk;

    argon_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_halt            (i_halt),
        .o_mem_req_valid   (o_mem_req_valid),
        .i_mem_req_ready   (i_mem_req_ready),
        .o_mem_addr        (o_mem_addr),
        .i_mem_rsp_valid   (i_mem_rsp_valid),
        .i_mem_rsp_data    (i_mem_rsp_data),
        .o_instr_valid     (o_instr_valid),
        .i_instr_ready     (i_instr_ready),
        .o_instruction     (o_instruction),
        .o_instr_pc        (o_instr_pc),
        .o_pc_plus4        (o_pc_plus4),
        .i_redirect_valid  (i_redirect_valid),
        .i_redirect_target (i_redirect_target),
        .o_fetch_count     (o_fetch_count),
        .o_fault           (o_fault)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory responder ----------------
    int          mem_k       = 1;
    bit          mem_corrupt = 1'b0;
    bit          mem_busy    = 1'b0;
    int          mem_cnt     = 0;
    logic [31:0] mem_a       = 32'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (!i_reset && o_mem_req_valid && i_mem_req_ready) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_k;
                mem_a    = o_mem_addr;
            end
        end
    end

    initial begin
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_rsp_valid = 1'b0;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    i_mem_rsp_valid = 1'b1;
                    i_mem_rsp_data  = mem_corrupt ? 32'hDEAD_BEEF : mem_word(mem_a);
                    mem_corrupt     = 1'b0;
                    mem_busy        = 1'b0;
                end
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    bit          chk_en  = 1'b0;
    int          cyc     = 0;
    logic [31:0] m_fetch = 32'h0;   // address the next request must carry
    bit          m_out   = 1'b0;    // a request is outstanding
    bit          m_disc  = 1'b0;    // outstanding response is stale
    logic [31:0] m_opc   = 32'h0;   // address of outstanding request
    bit          m_hold  = 1'b0;    // a word is waiting for decode
    logic [31:0] m_hpc   = 32'h0;
    logic [31:0] m_hdata = 32'h0;
    logic [31:0] m_count = 32'h0;
    bit          m_fault = 1'b0;

    logic [31:0] acc_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_p4[$];
    logic [31:0] dlv_data[$];
    int          dlv_cyc[$];

    initial begin
        bit          exp_rv, acc, redir;
        logic [31:0] tgt;
        bit          n_out, n_disc, n_hold, n_fault;
        logic [31:0] n_fetch, n_opc, n_hpc, n_hdata, n_count;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_rv = !m_out && !m_hold && !m_fault && !i_halt;
                check("req_valid", {31'd0, o_mem_req_valid}, {31'd0, exp_rv});
                if (exp_rv) check("mem_addr", o_mem_addr, m_fetch);
                check("instr_valid", {31'd0, o_instr_valid}, {31'd0, m_hold});
                if (m_hold) begin
                    check("instruction", o_instruction, m_hdata);
                    check("instr_pc", o_instr_pc, m_hpc);
                    check("pc_plus4", o_pc_plus4, m_hpc + 32'd4);
                end
                check("fetch_count", o_fetch_count, m_count);
                check("fault", {31'd0, o_fault}, {31'd0, m_fault});

                if (o_mem_req_valid && i_mem_req_ready) acc_log.push_back(o_mem_addr);
                if (o_instr_valid && i_instr_ready) begin
                    dlv_pc.push_back(o_instr_pc);
                    dlv_p4.push_back(o_pc_plus4);
                    dlv_data.push_back(o_instruction);
                    dlv_cyc.push_back(cyc);
                end

                acc   = exp_rv && i_mem_req_ready;
                redir = i_redirect_valid;
                tgt   = {i_redirect_target[31:2], 2'b00};
                n_out = m_out; n_disc = m_disc; n_opc = m_opc; n_hold = m_hold;
                n_hpc = m_hpc; n_hdata = m_hdata; n_fetch = m_fetch;
                n_count = m_count; n_fault = m_fault;
                if (m_hold) begin
                    if (i_instr_ready) n_count = m_count + 32'd1;
                    if (i_instr_ready || redir) n_hold = 1'b0;
                end
                if (m_out && i_mem_rsp_valid) begin
                    n_out = 1'b0;
                    if (!m_disc && !redir) begin
                        n_hold  = 1'b1;
                        n_hpc   = m_opc;
                        n_hdata = i_mem_rsp_data;
                        n_fetch = m_opc + 32'd4;
                    end
                end else if (m_out && redir) begin
                    n_disc = 1'b1;
                end
                if (acc) begin
                    n_out  = 1'b1;
                    n_opc  = m_fetch;
                    n_disc = redir;
                end
                if (redir) n_fetch = tgt;
`ifdef ARGON_FETCH_ALIGN_CHECK_EN
                if (redir && (i_redirect_target[1:0] != 2'b00)) n_fault = 1'b1;
`endif
                if (n_fault) begin
                    n_out  = 1'b0;
                    n_hold = 1'b0;
                end
                m_out = n_out; m_disc = n_disc; m_opc = n_opc; m_hold = n_hold;
                m_hpc = n_hpc; m_hdata = n_hdata; m_fetch = n_fetch;
                m_count = n_count; m_fault = n_fault;
                cyc++;
            end
        end
    end

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hBAD0_BAD1;
    endfunction

    function automatic logic [31:0] dpc_at(input int i);
        if (i < dlv_pc.size()) return dlv_pc[i];
        return 32'hBAD0_BAD1;
    endfunction

    function automatic logic [31:0] dp4_at(input int i);
        if (i < dlv_p4.size()) return dlv_p4[i];
        return 32'hBAD0_BAD1;
    endfunction

    function automatic logic [31:0] ddata_at(input int i);
        if (i < dlv_data.size()) return dlv_data[i];
        return 32'hBAD0_BAD1;
    endfunction

    function automatic logic [31:0] dcyc_at(input int i);
        if (i < dlv_cyc.size()) return 32'(dlv_cyc[i]);
        return 32'hBAD0_BAD1;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        i_halt = 1'b1;
        step(12);
    endtask

    // Watchdog: the directed sequence is fixed-length, this only guards hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int a0, d0;
        logic [31:0] c0;
        i_reset           = 1'b1;
        i_halt            = 1'b0;
        i_mem_req_ready   = 1'b1;
        i_instr_ready     = 1'b1;
        i_redirect_valid  = 1'b0;
        i_redirect_target = 32'h0;
        step(2);
        check("rst_req_valid", {31'd0, o_mem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, o_instr_valid}, 32'd0);
        check("rst_count", o_fetch_count, 32'd0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_fault", {31'd0, o_fault}, 32'd0);
        i_reset = 1'b0;
        chk_en  = 1'b1;

        // 1: k=1, immediate ready -> 0x0,0x4,0x8, one delivery every 3 cycles
        step(9);
        i_halt = 1'b1;
        check("t1_count", o_fetch_count, 32'd3);
        check("t1_addr0", acc_at(0), 32'h0);
        check("t1_addr1", acc_at(1), 32'h4);
        check("t1_addr2", acc_at(2), 32'h8);
        check("t1_dlv_cyc0", dcyc_at(0), 32'd2);
        check("t1_spacing", dcyc_at(1) - dcyc_at(0), 32'd3);
        check("t1_spacing2", dcyc_at(2) - dcyc_at(1), 32'd3);
        drain();

        // 2: k=4, decode stalls 5 cycles -> word held, no second request
        a0 = acc_log.size();
        mem_k = 4;
        i_instr_ready = 1'b0;
        i_halt = 1'b0;
        step(10);
        check("t2_one_req", 32'(acc_log.size() - a0), 32'd1);
        check("t2_valid", {31'd0, o_instr_valid}, 32'd1);
        check("t2_pc", o_instr_pc, 32'h0000_000C);
        check("t2_instr", o_instruction, 32'h1357_9BD3);
        i_instr_ready = 1'b1;
        i_halt = 1'b1;
        step(1);
        check("t2_count", o_fetch_count, 32'd4);
        drain();

        // 3: redirect 0x100 in WAIT, stale 0xDEADBEEF response dropped
        a0 = acc_log.size();
        d0 = dlv_pc.size();
        mem_k = 2;
        mem_corrupt = 1'b1;
        i_halt = 1'b0;
        step(1);
        i_redirect_valid  = 1'b1;
        i_redirect_target = 32'h0000_0100;
        mem_k = 1;
        step(1);
        i_redirect_valid = 1'b0;
        step(3);
        i_halt = 1'b1;
        step(1);
        drain();
        check("t3_addr_old", acc_at(a0), 32'h0000_0010);
        check("t3_addr_new", acc_at(a0 + 1), 32'h0000_0100);
        check("t3_dlv_n", 32'(dlv_pc.size() - d0), 32'd1);
        check("t3_pc", dpc_at(d0), 32'h0000_0100);
        check("t3_plus4", dp4_at(d0), 32'h0000_0104);
        check("t3_data", ddata_at(d0), 32'h1357_9ADF);

        // 4: redirect 0x40 in HOLD with decode ready -> counted, next addr 0x40
        a0 = acc_log.size();
        d0 = dlv_pc.size();
        c0 = o_fetch_count;
        mem_k = 1;
        i_halt = 1'b0;
        step(2);
        i_redirect_valid  = 1'b1;
        i_redirect_target = 32'h0000_0040;
        step(1);
        i_redirect_valid = 1'b0;
        check("t4_count_step", o_fetch_count - c0, 32'd1);
        step(1);
        i_halt = 1'b1;
        drain();
        check("t4_addr0", acc_at(a0), 32'h0000_0104);
        check("t4_addr1", acc_at(a0 + 1), 32'h0000_0040);
        check("t4_dlv_pc", dpc_at(d0 + 1), 32'h0000_0040);
        check("t4_count", o_fetch_count - c0, 32'd2);

        // 5: halt raised during WAIT -> word still delivered, then no requests
        a0 = acc_log.size();
        d0 = dlv_pc.size();
        mem_k = 3;
        i_halt = 1'b0;
        step(1);
        i_halt = 1'b1;
        step(7);
        check("t5_req_low", {31'd0, o_mem_req_valid}, 32'd0);
        check("t5_one_req", 32'(acc_log.size() - a0), 32'd1);
        check("t5_dlv_pc", dpc_at(d0), 32'h0000_0044);
        i_halt = 1'b0;
        mem_k = 1;
        step(1);
        i_halt = 1'b1;
        drain();
        check("t5_resume", acc_at(a0 + 1), 32'h0000_0048);

        // PC wrap: 0xFFFFFFFC + 4 -> 0
        a0 = acc_log.size();
        d0 = dlv_pc.size();
        i_redirect_valid  = 1'b1;
        i_redirect_target = 32'hFFFF_FFFC;
        step(1);
        i_redirect_valid = 1'b0;
        i_halt = 1'b0;
        step(3);
        step(1);
        i_halt = 1'b1;
        drain();
        check("wrap_addr", acc_at(a0), 32'hFFFF_FFFC);
        check("wrap_pc", dpc_at(d0), 32'hFFFF_FFFC);
        check("wrap_plus4", dp4_at(d0), 32'h0000_0000);
        check("wrap_next", acc_at(a0 + 1), 32'h0000_0000);

        // 6: misaligned redirect 0x102
        a0 = acc_log.size();
        i_redirect_valid  = 1'b1;
        i_redirect_target = 32'h0000_0102;
        step(1);
        i_redirect_valid = 1'b0;
        i_halt = 1'b0;
        step(1);
        i_halt = 1'b1;
        drain();
`ifdef ARGON_FETCH_ALIGN_CHECK_EN
        check("t6_fault", {31'd0, o_fault}, 32'd1);
        check("t6_no_req", 32'(acc_log.size() - a0), 32'd0);
`else
        check("t6_fault", {31'd0, o_fault}, 32'd0);
        check("t6_addr", acc_at(a0), 32'h0000_0100);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
